// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch: state encoding, debounce default and counter range.
// Imported by the control FSM, and intended for the counter and display blocks as well.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  localparam int DEFAULT_DB_CYCLES = 1_000_000;
  localparam int SW_COUNT_MAX      = 9999;

  typedef struct packed {
    logic run;
    logic stop;
    logic clear;
  } sw_cmd_t;

  // Exactly one command is active for every legal state; the unused code falls back to stop.
  function automatic sw_cmd_t state_to_cmd(input sw_state_e st);
    sw_cmd_t cmd;
    cmd = '{run: 1'b0, stop: 1'b0, clear: 1'b0};
    case (st)
      ST_RUN:   cmd.run   = 1'b1;
      ST_CLEAR: cmd.clear = 1'b1;
      default:  cmd.stop  = 1'b1;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge press pulse derived from the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= i_btn;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  // Any cycle where the synchronized input agrees with the stable level restarts the count,
  // so only an uninterrupted run of DB_CYCLES disagreeing samples moves the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_level = level_q;
  assign o_press = level_q & ~level_dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command FSM: turns debounced run/stop and clear presses into
// mutually exclusive run / stop / clear levels for the counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic [1:0] o_state
);

  sw_state_e state_q;
  sw_state_e state_d;
  sw_cmd_t   cmd;
  logic      run_stop_press;
  logic      clear_press;
  logic      run_stop_level_unused;
  logic      clear_level_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run_stop (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_btn_run_stop),
    .o_level (run_stop_level_unused),
    .o_press (run_stop_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (i_btn_clear),
    .o_level (clear_level_unused),
    .o_press (clear_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear wins over run/stop in STOP; RUN only listens to run/stop; CLEAR drops everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (clear_press) begin
          state_d = ST_CLEAR;
        end else if (run_stop_press) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_stop_press) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    cmd = state_to_cmd(state_q);
  end

  assign o_run   = cmd.run;
  assign o_stop  = cmd.stop;
  assign o_clear = cmd.clear;
  assign o_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl with DB_CYCLES=4, checked
// against a window-based debounce model and an abstract command-state model.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic       i_btn_run_stop;
  logic       i_btn_clear;
  logic       o_run;
  logic       o_stop;
  logic       o_clear;
  logic [1:0] o_state;

  int checks;
  int failures;

  // Model: per button, the raw samples taken at recent edges (index 0 = latest),
  // the accepted level, and a press waiting to act on the next edge.
  int hist_rs [0:7];
  int hist_cl [0:7];
  int lvl_rs, lvl_cl;
  int pend_rs, pend_cl;
  int m_state; // 0 stop, 1 run, 2 clear

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_btn_run_stop (i_btn_run_stop),
    .i_btn_clear    (i_btn_clear),
    .o_run          (o_run),
    .o_stop         (o_stop),
    .o_clear        (o_clear),
    .o_state        (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      hist_rs[i] = 0;
      hist_cl[i] = 0;
    end
    lvl_rs  = 0;
    lvl_cl  = 0;
    pend_rs = 0;
    pend_cl = 0;
    m_state = 0;
  endtask

  // The level flips once the DB samples preceding the most recent one all disagree with it
  // (the most recent sample is still inside the synchronizer).
  function automatic int window_flip(input int h [0:7], input int lvl);
    for (int i = 1; i <= DB; i++) begin
      if (h[i] == lvl) return 0;
    end
    return 1;
  endfunction

  task automatic model_edge(input int rs, input int cl);
    int rose_rs, rose_cl;
    case (m_state)
      0: if (pend_cl != 0) m_state = 2; else if (pend_rs != 0) m_state = 1;
      1: if (pend_rs != 0) m_state = 0;
      default: m_state = 0;
    endcase
    rose_rs = 0;
    rose_cl = 0;
    if (window_flip(hist_rs, lvl_rs) != 0) begin
      lvl_rs  = 1 - lvl_rs;
      rose_rs = lvl_rs;
    end
    if (window_flip(hist_cl, lvl_cl) != 0) begin
      lvl_cl  = 1 - lvl_cl;
      rose_cl = lvl_cl;
    end
    pend_rs = rose_rs;
    pend_cl = rose_cl;
    for (int i = 7; i > 0; i--) begin
      hist_rs[i] = hist_rs[i-1];
      hist_cl[i] = hist_cl[i-1];
    end
    hist_rs[0] = rs;
    hist_cl[0] = cl;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"}, {6'd0, o_state}, 8'(m_state));
    check({tag, ".run"},   {7'd0, o_run},   8'(m_state == 1));
    check({tag, ".stop"},  {7'd0, o_stop},  8'(m_state == 0));
    check({tag, ".clear"}, {7'd0, o_clear}, 8'(m_state == 2));
    check({tag, ".onehot"}, {7'd0, $onehot({o_run, o_stop, o_clear})}, 8'd1);
  endtask

  task automatic step(input logic rs, input logic cl, input string tag);
    @(negedge clk);
    i_btn_run_stop = rs;
    i_btn_clear    = cl;
    @(posedge clk);
    model_edge(int'(rs), int'(cl));
    #1;
    check_outputs(tag);
  endtask

  task automatic steps(input int n, input logic rs, input logic cl, input string tag);
    for (int i = 0; i < n; i++) step(rs, cl, tag);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must react immediately.
  task automatic reset_pulse(input string tag);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_state"}, {6'd0, o_state}, 8'd0);
    check({tag, ".rst_stop"},  {7'd0, o_stop},  8'd1);
    check({tag, ".rst_run"},   {7'd0, o_run},   8'd0);
    check({tag, ".rst_clear"}, {7'd0, o_clear}, 8'd0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int rs_r, cl_r, len;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    model_reset();
    #2;
    check("init.stop", {7'd0, o_stop}, 8'd1);
    check("init.state", {6'd0, o_state}, 8'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    steps(3, 1'b0, 1'b0, "idle");

    // Run/stop toggle with exact latency: edge 6 after the first high sample.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, "run_hold");
      if (i == 5) check("latency.before", {6'd0, o_state}, 8'd0);
      if (i == 6) check("latency.at", {6'd0, o_state}, 8'd1);
    end
    steps(10, 1'b0, 1'b0, "run_rel");
    steps(10, 1'b1, 1'b0, "stop_hold");
    check("toggle.stop", {7'd0, o_stop}, 8'd1);
    steps(10, 1'b0, 1'b0, "stop_rel");

    // Bounce: 3 high / 1 low never satisfies the stability window.
    for (int k = 0; k < 5; k++) begin
      steps(3, 1'b1, 1'b0, "bounce_hi");
      steps(1, 1'b0, 1'b0, "bounce_lo");
    end
    check("bounce.stop", {6'd0, o_state}, 8'd0);
    steps(8, 1'b1, 1'b0, "bounce_hold");
    check("bounce.run", {6'd0, o_state}, 8'd1);
    steps(10, 1'b0, 1'b0, "bounce_rel");

    // Clear ignored in RUN, then back to STOP, then clear from STOP.
    steps(10, 1'b0, 1'b1, "clr_in_run");
    check("clr_run.run", {7'd0, o_run}, 8'd1);
    steps(10, 1'b0, 1'b0, "clr_rel");
    steps(10, 1'b1, 1'b0, "to_stop");
    steps(10, 1'b0, 1'b0, "to_stop_rel");
    steps(10, 1'b0, 1'b1, "clr_in_stop");
    steps(10, 1'b0, 1'b0, "clr_stop_rel");

    // Simultaneous rise in STOP: clear has priority.
    steps(10, 1'b1, 1'b1, "both");
    steps(10, 1'b0, 1'b0, "both_rel");
    check("both.stop", {7'd0, o_stop}, 8'd1);

    // Reset while the run/stop counter is mid-count, button still held.
    steps(4, 1'b1, 1'b0, "middb");
    reset_pulse("middb");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, "middb_hold");
      if (i == 5) check("middb.before", {6'd0, o_state}, 8'd0);
      if (i == 6) check("middb.at", {6'd0, o_state}, 8'd1);
    end
    // Reset in RUN with the button still high.
    reset_pulse("run_rst");
    steps(10, 1'b1, 1'b0, "run_rst_hold");
    steps(10, 1'b0, 1'b0, "run_rst_rel");

    // Randomized bursts on both buttons, with occasional resets.
    for (int b = 0; b < 80; b++) begin
      rs_r = int'($urandom_range(0, 1));
      cl_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      len  = int'($urandom_range(1, 12));
      steps(len, rs_r[0], cl_r[0], "rand");
      if ($urandom_range(0, 19) == 0) reset_pulse("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
